// File: rtl/uart_rx_phy_if.sv
// uart_rx_phy_if: receive-side result bus (byte, good/error strobes, busy) of the UART RX front end.
// The PHY drives it through the master modport; the receive FIFO write port reads the slave modport.
interface uart_rx_phy_if;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              frame_err_o;
    logic              busy_o;

    modport master (output data_o, valid_o, frame_err_o, busy_o);
    modport slave  (input  data_o, valid_o, frame_err_o, busy_o);
endinterface

// File: rtl/uart_rx_phy.sv
// uart_rx_phy: UART receive front end -- line synchronizer, start-bit qualification, LSB-first
// mid-bit sampling and stop-bit check. Define UART_RX_MAJORITY_EN for 2-of-3 voting around mid-bit.
module uart_rx_phy #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [15:0]   baud_div_i,
    input  logic          en_i,
    input  logic          rx_bit_i,
    uart_rx_phy_if.master bus
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             r_state, w_state_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic [IDX_W-1:0]   r_idx, w_idx_d;
    logic [DATA_W-1:0]  r_shift, w_shift_d;
    logic [DATA_W-1:0]  r_data, w_data_d;
    logic               r_valid, w_valid_d;
    logic               r_ferr, w_ferr_d;
    logic               r_busy, w_busy_d;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_line;

    logic [CNT_W-1:0]   w_half;
    logic [CNT_W-1:0]   w_last;
    logic               w_wrap;
    logic               w_div_ok;
    logic               w_samp_pt;
    logic               w_samp;

    assign w_half   = baud_div_i >> 1;
    assign w_last   = baud_div_i - CNT_W'(1);
    assign w_wrap   = (r_cnt >= w_last);
    assign w_div_ok = (baud_div_i >= CNT_W'(4));

    // Metastability synchronizer plus one registered copy the FSM treats as the line.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync <= '1;
            r_line <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_bit_i};
            r_line <= r_sync[SYNC_STAGES-1];
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic r_vote0;
    logic r_vote1;

    // Capture the line one cycle before and at mid-bit; the vote resolves one cycle after.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_vote0 <= 1'b1;
            r_vote1 <= 1'b1;
        end else begin
            if (r_cnt == w_half - CNT_W'(1)) r_vote0 <= r_line;
            if (r_cnt == w_half)             r_vote1 <= r_line;
        end
    end

    assign w_samp_pt = (r_cnt == w_half + CNT_W'(1));
    assign w_samp    = (r_vote0 & r_vote1) | (r_vote0 & r_line) | (r_vote1 & r_line);
`else
    assign w_samp_pt = (r_cnt == w_half);
    assign w_samp    = r_line;
`endif

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            r_shift <= w_shift_d;
            r_data  <= w_data_d;
            r_valid <= w_valid_d;
            r_ferr  <= w_ferr_d;
            r_busy  <= w_busy_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = '0;
        w_idx_d   = r_idx;
        w_shift_d = r_shift;
        w_data_d  = r_data;
        w_valid_d = 1'b0;
        w_ferr_d  = 1'b0;

        if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
            w_cnt_d = w_wrap ? '0 : r_cnt + CNT_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (!r_line) w_state_d = S_START;
            end
            S_START: begin
                if (w_samp_pt && w_samp) begin
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                end else if (w_wrap) begin
                    w_state_d = S_DATA;
                    w_idx_d   = '0;
                end
            end
            S_DATA: begin
                if (w_samp_pt) w_shift_d[r_idx] = w_samp;
                if (w_wrap) begin
                    if (r_idx == IDX_W'(DATA_W - 1)) w_state_d = S_STOP;
                    w_idx_d = r_idx + IDX_W'(1);
                end
            end
            S_STOP: begin
                // Decide at mid stop bit so a following start edge is never missed.
                if (w_samp_pt) begin
                    w_data_d = r_shift;
                    w_cnt_d  = '0;
                    if (w_samp) begin
                        w_valid_d = 1'b1;
                        w_state_d = S_IDLE;
                    end else begin
                        w_ferr_d  = 1'b1;
                        w_state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (r_line) w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Disable or an unusably small divisor drops any partial frame silently.
        if (!en_i || !w_div_ok) begin
            w_state_d = S_IDLE;
            w_cnt_d   = '0;
            w_data_d  = r_data;
            w_valid_d = 1'b0;
            w_ferr_d  = 1'b0;
        end

        w_busy_d = (w_state_d != S_IDLE);
    end

    assign bus.data_o      = r_data;
    assign bus.valid_o     = r_valid;
    assign bus.frame_err_o = r_ferr;
    assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_uart_rx_phy.sv
// tb_uart_rx_phy: directed and randomized frames against an arithmetic model of strobe timing,
// byte value and strobe kind for uart_rx_phy.
module tb_uart_rx_phy;
    localparam int S = 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud;
    logic        en;
    logic        rx;

    uart_rx_phy_if u_if ();

    uart_rx_phy #(.SYNC_STAGES(S)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .baud_div_i (baud),
        .en_i       (en),
        .rx_bit_i   (rx),
        .bus        (u_if)
    );

    always #5 clk = ~clk;

    // kind: 0 good byte, 1 framing error, 2 both strobes at once
    typedef struct {
        int cyc;
        int data;
        int kind;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc = 0;
    int  n_pass = 0;
    int  n_fail = 0;
    int  n_total = 0;
    bit  busy_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with the number of clock edges seen so far.
    always @(negedge clk) begin : mon
        ev_t ev;
        if (u_if.busy_o) busy_seen = 1'b1;
        if (u_if.valid_o || u_if.frame_err_o) begin
            ev.cyc  = cyc;
            ev.data = int'(u_if.data_o);
            ev.kind = (u_if.valid_o && u_if.frame_err_o) ? 2 : (u_if.frame_err_o ? 1 : 0);
            obs_q.push_back(ev);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_%0d_cycle", tag, i), obs_q[i].cyc,  exp_q[i].cyc);
            chk($sformatf("%s_%0d_data",  tag, i), obs_q[i].data, exp_q[i].data);
            chk($sformatf("%s_%0d_kind",  tag, i), obs_q[i].kind, exp_q[i].kind);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame cycle by cycle; the model predicts the strobe edge from the start-capture edge.
    task automatic drive_frame(input logic [7:0] d, input logic stop_val, input int b, input int stop_cyc,
                               input int drop_at, input int glitch_at, input bit exp_ev,
                               input logic [7:0] exp_d);
        logic [9:0] bits;
        int         e0;
        int         k;
        int         n;
        ev_t        ev;
        bits = {stop_val, d, 1'b0};
        k    = 0;
        @(negedge clk);
        baud = 16'(b);
        e0   = cyc + 1;
        if (exp_ev) begin
            ev.cyc  = e0 + S + 9 * b + b / 2 + 2 + MAJ;
            ev.data = int'(exp_d);
            ev.kind = stop_val ? 0 : 1;
            exp_q.push_back(ev);
        end
        for (int i = 0; i < 10; i++) begin
            n = (i == 9) ? stop_cyc : b;
            for (int j = 0; j < n; j++) begin
                rx = (k == glitch_at) ? ~bits[i] : bits[i];
                if (k == drop_at) en = 1'b0;
                if (drop_at >= 0 && k == drop_at + 1) chk("busy_after_en_drop", u_if.busy_o, 0);
                k++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [7:0] rb;
        int         b;

        rst_n = 1'b0;
        en    = 1'b1;
        baud  = 16'd16;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data",  u_if.data_o,      0);
        chk("reset_valid", u_if.valid_o,     0);
        chk("reset_ferr",  u_if.frame_err_o, 0);
        chk("reset_busy",  u_if.busy_o,      0);
        rst_n = 1'b1;
        idle(4);

        // Single good frame.
        drive_frame(8'hA5, 1'b1, 16, 15, -1, -1, 1'b1, 8'hA5);
        idle(4);
        check_events("a5");
        chk("a5_busy_after", u_if.busy_o, 0);

        // Back-to-back frames with one stop bit each.
        drive_frame(8'h00, 1'b1, 10, 9, -1, -1, 1'b1, 8'h00);
        drive_frame(8'hFF, 1'b1, 10, 9, -1, -1, 1'b1, 8'hFF);
        drive_frame(8'h55, 1'b1, 10, 9, -1, -1, 1'b1, 8'h55);
        idle(5);
        check_events("b2b");

        // Short low glitch on the idle line.
        @(negedge clk);
        baud      = 16'd16;
        busy_seen = 1'b0;
        rx        = 1'b0;
        repeat (3) @(negedge clk);
        idle(48);
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_busy_end",  u_if.busy_o, 0);
        check_events("glitch");

        // Low stop bit followed by a long break, then a fresh frame.
        drive_frame(8'h3C, 1'b0, 16, 40 * 16, -1, -1, 1'b1, 8'h3C);
        chk("break_data_held", u_if.data_o, 8'h3C);
        check_events("break");
        idle(20);
        drive_frame(8'h5A, 1'b1, 16, 15, -1, -1, 1'b1, 8'h5A);
        idle(4);
        check_events("after_break");

        // Receiver disabled in the middle of data bit 4.
        drive_frame(8'hE7, 1'b1, 16, 15, 5 * 16 + 3, -1, 1'b0, 8'h00);
        chk("endrop_data_held", u_if.data_o, 8'h5A);
        idle(8);
        en = 1'b1;
        idle(4);
        check_events("endrop_none");
        drive_frame(8'h81, 1'b1, 16, 15, -1, -1, 1'b1, 8'h81);
        idle(4);
        check_events("after_endrop");

        // One-cycle inversion of data bit 2 exactly at its mid-bit sample.
`ifdef UART_RX_MAJORITY_EN
        drive_frame(8'h00, 1'b1, 16, 15, -1, 1 + 3 * 16 + 8, 1'b1, 8'h00);
`else
        drive_frame(8'h00, 1'b1, 16, 15, -1, 1 + 3 * 16 + 8, 1'b1, 8'h04);
`endif
        idle(4);
        check_events("midbit_glitch");

        // Random bytes in back-to-back groups at random divisors.
        for (int g = 0; g < 4; g++) begin
            b = int'($urandom_range(24, 6));
            for (int f = 0; f < 3; f++) begin
                rb = 8'($urandom);
                drive_frame(rb, 1'b1, b, b - 1, -1, -1, 1'b1, rb);
            end
            idle(2 * b);
            check_events($sformatf("rand_g%0d", g));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_phy.md
# uart_rx_phy

Bit-level UART receive front end: synchronizes the asynchronous serial input, detects and qualifies the start bit, samples eight data bits LSB-first at mid-bit, and checks the stop bit. Each completed frame is delivered as a one-cycle byte strobe that feeds the receive FIFO write port inside the UART receive path. The block has no storage beyond one output byte; buffering and overrun handling belong to the FIFO downstream.

## Interface
- SYNC_STAGES, 2, number of synchronizer flops on rx_bit_i (legal 2..4)
- clk_i  in  1  system clock
- rst_ni  in  1  reset; one clock, synchronous, active-low
- baud_div_i  in  16  bit period in clk_i cycles (B); shared with the transmitter
- en_i  in  1  receiver enable (control register rx_en bit)
- rx_bit_i  in  1  asynchronous serial line, idle high
- data_o  out  8  last received byte; held until the next frame end
- valid_o  out  1  one-cycle strobe: good frame, data_o valid (drives FIFO write)
- frame_err_o  out  1  one-cycle strobe: stop bit sampled low
- busy_o  out  1  high whenever state is not IDLE

## Operation
- Reset: data_o=0, valid_o=0, frame_err_o=0, busy_o=0, state=IDLE, all synchronizer flops=1.
- States: IDLE, START, DATA, STOP, BREAK.
- Bit counter cnt (16 bit) runs in START/DATA/STOP; cnt wraps to 0 when cnt >= B-1 (>= so a mid-frame baud_div_i decrease cannot lock up). Mid-point h = B>>1.
- IDLE: synced line = 0 and en_i=1 -> START, cnt=0.
- START: at the sample point, line 1 -> IDLE (glitch rejected, no strobe); line 0 -> wait for cnt wrap -> DATA, bit index 0.
- DATA: sample at the sample point into bit [index]; on wrap, index+1; after index 7 wraps -> STOP.
- STOP: at the sample point: line 1 -> data_o updated, valid_o pulse, -> IDLE immediately (no wait for the end of the stop bit). Line 0 -> data_o updated, frame_err_o pulse, -> BREAK.
- BREAK: stay until synced line = 1, then -> IDLE. This keeps a held-low line from producing repeated frames.
- en_i=0 in any state: next cycle state=IDLE, cnt=0, the partial frame is discarded, no strobe. data_o is kept.
- B < 4: receiver is held in IDLE; the line is ignored.
- valid_o and frame_err_o are never high in the same cycle. The block does no backpressure; each strobe lasts exactly one cycle.

## Timing
- Edge 0 is the clock edge at which the first synchronizer flop captures the low start bit. S = SYNC_STAGES.
- The START transition is registered at edge S+1. cnt equals m after edge S+1+m within the start bit.
- Sample point without the macro: cnt==h. The stop decision is registered at edge S+9B+h+2. valid_o/frame_err_o are high during the cycle that follows and low one edge later.
- With UART_RX_MAJORITY_EN, the decision moves one edge later: S+9B+h+3.
- Start-glitch rejection occurs at the same relative sample point within the start bit.
- Back-to-back frames: a start edge arriving half a bit after the stop mid-point is accepted with no lost frame.

## Configuration
- UART_RX_MAJORITY_EN defined: at each sample point the block takes the 2-of-3 majority of the synced line at cnt = h-1, h, h+1. The decision is taken at cnt==h+1. This applies to the start-glitch check, the data bits and the stop bit.
- UART_RX_MAJORITY_EN undefined: single sample at cnt==h; no vote registers.

## Test plan
- Reset, B=16, en_i=1, send 0xA5 with a good stop bit -> one valid_o pulse with data_o=0xA5 at edge S+9*16+8+2; frame_err_o stays 0; busy_o low afterwards.
- Send 0x00, then 0xFF, then 0x55 back-to-back with one stop bit each at B=10 -> three valid_o pulses, bytes in order, no frame_err_o.
- Low pulse of 3 cycles on the idle line, B=16 -> busy_o goes high briefly, returns to IDLE, no strobes.
- Frame 0x3C with the stop bit forced low and the line then held low for 40 bit times -> exactly one frame_err_o with data_o=0x3C; no further strobes until the line goes high and a new start bit arrives.
- Drop en_i at data bit 4 of a frame, then re-raise it -> no strobe; busy_o=0 one cycle after en_i falls; the next full frame 0x81 is received correctly.
- With UART_RX_MAJORITY_EN, B=16, invert the line only at cnt==h of data bit 2 in frame 0x00 -> data_o=0x00. Without the macro -> data_o=0x04.
